// File: rtl/data_worker_arbiter.sv
// data_worker_arbiter
// Round-robin front end that shares one data_worker AHB burst engine among
// pNUM_REQ requesters. One 128-bit job is in flight at a time; go is held
// until the worker reports done (or the watchdog expires), then a one-cycle
// ack (plus err on failure) is returned to the granted requester.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   I_req / I_req_write per-requester request level and direction (1 = write)
//   I_req_addr/_wdata   packed per-requester address / write payload
//   O_req_ack/_err      one-hot completion pulse and coincident error pulse
//   O_req_rdata         read payload, valid while ack is high for a read
//   O_wk_go/_write/_addr/_wdata   worker job port (I_go, I_int_*)
//   I_wk_done, I_wk_rdata, I_wk_rdata_valid   worker completion and read data
//   O_busy              high whenever the controller is not idle
//   O_grant_id          index of the current or last granted requester
module data_worker_arbiter #(
    parameter int unsigned pNUM_REQ           = 4,
    parameter int unsigned pAHB_ADDR_WIDTH    = 32,
    parameter int unsigned pPAYLOAD_SIZE_BITS = 128,
    parameter int unsigned pTIMEOUT_CYCLES    = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [pNUM_REQ-1:0]                    I_req,
    input  logic [pNUM_REQ-1:0]                    I_req_write,
    input  logic [pNUM_REQ*pAHB_ADDR_WIDTH-1:0]    I_req_addr,
    input  logic [pNUM_REQ*pPAYLOAD_SIZE_BITS-1:0] I_req_wdata,
    output logic [pNUM_REQ-1:0]                    O_req_ack,
    output logic [pNUM_REQ-1:0]                    O_req_err,
    output logic [pPAYLOAD_SIZE_BITS-1:0]          O_req_rdata,
    output logic                                   O_wk_go,
    output logic                                   O_wk_write,
    output logic [pAHB_ADDR_WIDTH-1:0]             O_wk_addr,
    output logic [pPAYLOAD_SIZE_BITS-1:0]          O_wk_wdata,
    input  logic                                   I_wk_done,
    input  logic [pPAYLOAD_SIZE_BITS-1:0]          I_wk_rdata,
    input  logic                                   I_wk_rdata_valid,
    output logic                                   O_busy,
    output logic [$clog2(pNUM_REQ)-1:0]            O_grant_id
);

    localparam int unsigned IDW = $clog2(pNUM_REQ);
    localparam int unsigned CW  = $clog2(pTIMEOUT_CYCLES) + 1;

    localparam logic [CW-1:0]       CNT_LAST = CW'(pTIMEOUT_CYCLES - 1);
    localparam logic [pNUM_REQ-1:0] ONE_HOT0 = pNUM_REQ'(1);
    localparam logic [IDW-1:0]      PTR_RST  = IDW'(pNUM_REQ - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]                    state_q, state_d;
    logic [IDW-1:0]                ptr_q, ptr_d;
    logic [pNUM_REQ-1:0]           mask_q, mask_d;
    logic                          rdv_q, rdv_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [pPAYLOAD_SIZE_BITS-1:0] buf_q, buf_d;

    logic [pNUM_REQ-1:0]           ack_d, err_d;
    logic [pPAYLOAD_SIZE_BITS-1:0] rdata_d;
    logic                          go_d, wk_write_d, busy_d;
    logic [pAHB_ADDR_WIDTH-1:0]    wk_addr_d;
    logic [pPAYLOAD_SIZE_BITS-1:0] wk_wdata_d;
    logic [IDW-1:0]                gid_d;

    logic [pNUM_REQ-1:0]           eligible_c;
    logic [IDW-1:0]                cand_c;
    logic [IDW-1:0]                grant_idx_c;
    logic                          grant_found_c;
    logic                          rd_ok_c;

    // Round-robin pick: scan from the farthest candidate down so the nearest
    // eligible index after the pointer is the one that sticks.
    always_comb begin
        eligible_c    = I_req & ~mask_q;
        cand_c        = '0;
        grant_idx_c   = '0;
        grant_found_c = 1'b0;
        for (int unsigned k = pNUM_REQ; k >= 1; k--) begin
            cand_c = IDW'((32'(ptr_q) + k) % pNUM_REQ);
            if (eligible_c[cand_c]) begin
                grant_idx_c   = cand_c;
                grant_found_c = 1'b1;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        mask_d     = '0;
        rdv_d      = rdv_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        ack_d      = '0;
        err_d      = '0;
        rdata_d    = O_req_rdata;
        go_d       = O_wk_go;
        wk_write_d = O_wk_write;
        wk_addr_d  = O_wk_addr;
        wk_wdata_d = O_wk_wdata;
        gid_d      = O_grant_id;
        // Read data arriving on the done edge counts as captured.
        rd_ok_c    = rdv_q | I_wk_rdata_valid;

        case (state_q)
            ST_IDLE: begin
                if (grant_found_c) begin
                    wk_write_d = I_req_write[grant_idx_c];
                    wk_addr_d  = I_req_addr[32'(grant_idx_c)*pAHB_ADDR_WIDTH +: pAHB_ADDR_WIDTH];
                    wk_wdata_d = I_req_wdata[32'(grant_idx_c)*pPAYLOAD_SIZE_BITS +: pPAYLOAD_SIZE_BITS];
                    ptr_d      = grant_idx_c;
                    gid_d      = grant_idx_c;
                    go_d       = 1'b1;
                    cnt_d      = '0;
                    rdv_d      = 1'b0;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (I_wk_rdata_valid) begin
                    buf_d = I_wk_rdata;
                    rdv_d = 1'b1;
                end
                // Done takes priority over a coincident watchdog expiry.
                if (I_wk_done || (cnt_q == CNT_LAST)) begin
                    go_d         = 1'b0;
                    ack_d[ptr_q] = 1'b1;
                    state_d      = ST_RESP;
                    if (I_wk_done) begin
                        err_d[ptr_q] = ~O_wk_write & ~rd_ok_c;
                    end else begin
                        err_d[ptr_q] = 1'b1;
                    end
                    if (!O_wk_write) begin
                        rdata_d = I_wk_rdata_valid ? I_wk_rdata : buf_q;
                    end
                end
            end
            ST_RESP: begin
                // Block the just-served requester for one IDLE cycle so a
                // registered drop of its request is not mistaken for a new one.
                mask_d  = ONE_HOT0 << ptr_q;
                state_d = ST_IDLE;
            end
            default: begin
                go_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PTR_RST;
            mask_q      <= '0;
            rdv_q       <= 1'b0;
            cnt_q       <= '0;
            buf_q       <= '0;
            O_req_ack   <= '0;
            O_req_err   <= '0;
            O_req_rdata <= '0;
            O_wk_go     <= 1'b0;
            O_wk_write  <= 1'b0;
            O_wk_addr   <= '0;
            O_wk_wdata  <= '0;
            O_busy      <= 1'b0;
            O_grant_id  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mask_q      <= mask_d;
            rdv_q       <= rdv_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            O_req_ack   <= ack_d;
            O_req_err   <= err_d;
            O_req_rdata <= rdata_d;
            O_wk_go     <= go_d;
            O_wk_write  <= wk_write_d;
            O_wk_addr   <= wk_addr_d;
            O_wk_wdata  <= wk_wdata_d;
            O_busy      <= busy_d;
            O_grant_id  <= gid_d;
        end
    end

endmodule

// File: tb/tb_data_worker_arbiter.sv
// Testbench for data_worker_arbiter: cycle tables for the write, round-robin
// and mask scenarios, plus hand-written read, timeout and reset sequences.
module tb_data_worker_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 128;
    localparam int unsigned T  = 64;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ack;
    logic [N-1:0]    req_err;
    logic [DW-1:0]   req_rdata;
    logic            wk_go;
    logic            wk_write;
    logic [AW-1:0]   wk_addr;
    logic [DW-1:0]   wk_wdata;
    logic            wk_done;
    logic [DW-1:0]   wk_rdata;
    logic            wk_rdata_valid;
    logic            busy;
    logic [1:0]      grant_id;

    data_worker_arbiter #(
        .pNUM_REQ(N), .pAHB_ADDR_WIDTH(AW),
        .pPAYLOAD_SIZE_BITS(DW), .pTIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst),
        .I_req(req), .I_req_write(req_write),
        .I_req_addr(req_addr), .I_req_wdata(req_wdata),
        .O_req_ack(req_ack), .O_req_err(req_err), .O_req_rdata(req_rdata),
        .O_wk_go(wk_go), .O_wk_write(wk_write),
        .O_wk_addr(wk_addr), .O_wk_wdata(wk_wdata),
        .I_wk_done(wk_done), .I_wk_rdata(wk_rdata),
        .I_wk_rdata_valid(wk_rdata_valid),
        .O_busy(busy), .O_grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic       go;
        logic [3:0] ack;
        logic [3:0] err;
        logic       busy;
        logic [1:0] gid;
    } vec_t;

    vec_t          vecs[$];
    logic [AW-1:0] addr_tab [N];
    logic [DW-1:0] wdata_tab[N];
    logic [N-1:0]  write_tab;
    int            n_cmp;
    int            n_fail;

    localparam logic [DW-1:0] RD_VAL1 = 128'hDEADBEEF_00112233_44556677_8899AABB;
    localparam logic [DW-1:0] RD_VAL2 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

    function automatic void add(input logic r, input logic [3:0] rq, input logic d,
                                input logic g, input logic [3:0] a, input logic [3:0] e,
                                input logic b, input logic [1:0] id);
        vec_t v;
        v.rst = r; v.req = rq; v.done = d;
        v.go = g; v.ack = a; v.err = e; v.busy = b; v.gid = id;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   hi;
        logic go_ok;
        n_cmp  = 0;
        n_fail = 0;

        addr_tab  = '{32'h08, 32'h14, 32'h20, 32'h40};
        wdata_tab = '{128'h01c3001967d4acf1bcb25768708627ae,
                      128'h11111111_22222222_33333333_44444444,
                      128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C,
                      128'h0};
        write_tab = 4'b0111;
        for (int i = 0; i < int'(N); i++) begin
            req_addr[i*AW +: AW]  = addr_tab[i];
            req_wdata[i*DW +: DW] = wdata_tab[i];
        end
        req_write      = write_tab;
        rst            = 1'b1;
        req            = '0;
        wk_done        = 1'b0;
        wk_rdata       = '0;
        wk_rdata_valid = 1'b0;
        step();
        step();

        chk("reset go",    128'(wk_go),     128'(0));
        chk("reset ack",   128'(req_ack),   128'(0));
        chk("reset err",   128'(req_err),   128'(0));
        chk("reset busy",  128'(busy),      128'(0));
        chk("reset gid",   128'(grant_id),  128'(0));
        chk("reset addr",  128'(wk_addr),   128'(0));
        chk("reset rdata", 128'(req_rdata), 128'(0));
        rst = 1'b0;

        // Single write, done after 6 go cycles, then requester 0 holds req
        // across its ack: masked for one IDLE cycle, granted again after.
        add(0, 4'b0001, 0, 1, 4'b0000, 4'b0000, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 4'b0001, 0, 1, 4'b0000, 4'b0000, 1, 0);
        add(0, 4'b0001, 1, 0, 4'b0001, 4'b0000, 1, 0);
        add(0, 4'b0001, 0, 0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0001, 0, 0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0001, 0, 1, 4'b0000, 4'b0000, 1, 0);
        add(0, 4'b0001, 1, 0, 4'b0001, 4'b0000, 1, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);
        // Round robin with all four requesting; 3 is a read with no data (err).
        add(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b1111, 0, 1, 4'b0000, 4'b0000, 1, 0);
        add(0, 4'b1111, 1, 0, 4'b0001, 4'b0000, 1, 0);
        add(0, 4'b1111, 0, 0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b1110, 0, 1, 4'b0000, 4'b0000, 1, 1);
        add(0, 4'b1110, 1, 0, 4'b0010, 4'b0000, 1, 1);
        add(0, 4'b1110, 0, 0, 4'b0000, 4'b0000, 0, 1);
        add(0, 4'b1100, 0, 1, 4'b0000, 4'b0000, 1, 2);
        add(0, 4'b1100, 1, 0, 4'b0100, 4'b0000, 1, 2);
        add(0, 4'b1100, 0, 0, 4'b0000, 4'b0000, 0, 2);
        add(0, 4'b1000, 0, 1, 4'b0000, 4'b0000, 1, 3);
        add(0, 4'b1000, 1, 0, 4'b1000, 4'b1000, 1, 3);
        add(0, 4'b1000, 0, 0, 4'b0000, 4'b0000, 0, 3);
        add(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3);
        add(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 3);
        // Simultaneous 0 and 2, requester 0 keeps requesting: order 0, 2, 0.
        add(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0101, 0, 1, 4'b0000, 4'b0000, 1, 0);
        add(0, 4'b0101, 1, 0, 4'b0001, 4'b0000, 1, 0);
        add(0, 4'b0101, 0, 0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0101, 0, 1, 4'b0000, 4'b0000, 1, 2);
        add(0, 4'b0101, 1, 0, 4'b0100, 4'b0000, 1, 2);
        add(0, 4'b0101, 0, 0, 4'b0000, 4'b0000, 0, 2);
        add(0, 4'b0001, 0, 1, 4'b0000, 4'b0000, 1, 0);
        add(0, 4'b0001, 1, 0, 4'b0001, 4'b0000, 1, 0);
        add(0, 4'b0001, 0, 0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);

        foreach (vecs[i]) begin
            rst     = vecs[i].rst;
            req     = vecs[i].req;
            wk_done = vecs[i].done;
            step();
            chk($sformatf("row%0d go", i),   128'(wk_go),    128'(vecs[i].go));
            chk($sformatf("row%0d ack", i),  128'(req_ack),  128'(vecs[i].ack));
            chk($sformatf("row%0d err", i),  128'(req_err),  128'(vecs[i].err));
            chk($sformatf("row%0d busy", i), 128'(busy),     128'(vecs[i].busy));
            chk($sformatf("row%0d gid", i),  128'(grant_id), 128'(vecs[i].gid));
            if (vecs[i].go) begin
                chk($sformatf("row%0d addr", i),  128'(wk_addr),  128'(addr_tab[vecs[i].gid]));
                chk($sformatf("row%0d wdata", i), wk_wdata,       wdata_tab[vecs[i].gid]);
                chk($sformatf("row%0d write", i), 128'(wk_write), 128'(write_tab[vecs[i].gid]));
            end
        end
        rst = 1'b0; req = '0; wk_done = 1'b0;

        // Read with data on the done edge.
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1000; step();
        chk("read go",    128'(wk_go),    128'(1));
        chk("read gid",   128'(grant_id), 128'(3));
        chk("read addr",  128'(wk_addr),  128'(32'h40));
        chk("read write", 128'(wk_write), 128'(0));
        step(); step();
        wk_done = 1'b1; wk_rdata_valid = 1'b1; wk_rdata = RD_VAL1;
        step();
        wk_done = 1'b0; wk_rdata_valid = 1'b0; wk_rdata = '0;
        chk("read ack",   128'(req_ack),  128'(4'b1000));
        chk("read err",   128'(req_err),  128'(0));
        chk("read rdata", req_rdata,      RD_VAL1);
        chk("read go low", 128'(wk_go),   128'(0));
        step();
        chk("read ack one cycle", 128'(req_ack), 128'(0));
        req = '0; step();

        // Read data arriving before done, then done alone.
        req = 4'b1000; step();
        chk("early rd go", 128'(wk_go), 128'(1));
        wk_rdata_valid = 1'b1; wk_rdata = RD_VAL2; step();
        wk_rdata_valid = 1'b0; wk_rdata = '0; step(); step();
        wk_done = 1'b1; step(); wk_done = 1'b0;
        chk("early rd ack",   128'(req_ack), 128'(4'b1000));
        chk("early rd err",   128'(req_err), 128'(0));
        chk("early rd rdata", req_rdata,     RD_VAL2);
        step(); req = '0; step();

        // Read completed without any data is an error.
        req = 4'b1000; step();
        wk_done = 1'b1; step(); wk_done = 1'b0;
        chk("nodata ack", 128'(req_ack), 128'(4'b1000));
        chk("nodata err", 128'(req_err), 128'(4'b1000));
        step(); req = '0; step();

        // Watchdog: worker never finishes requester 0's job.
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b0011; step();
        chk("to grant gid", 128'(grant_id), 128'(0));
        hi = wk_go ? 1 : 0;
        for (int i = 0; i < int'(T) + 8; i++) begin
            step();
            if (!wk_go) break;
            hi++;
        end
        chk("to go cycles", 128'(hi),      128'(T));
        chk("to ack",       128'(req_ack), 128'(4'b0001));
        chk("to err",       128'(req_err), 128'(4'b0001));
        step();
        chk("to ack one cycle", 128'(req_ack), 128'(0));
        req = 4'b0010; step();
        chk("to next go",  128'(wk_go),    128'(1));
        chk("to next gid", 128'(grant_id), 128'(1));

        // Done on the same edge the watchdog would fire: no error.
        go_ok = 1'b1;
        for (int i = 0; i < int'(T) - 1; i++) begin
            step();
            if (!wk_go) go_ok = 1'b0;
        end
        chk("edge go held", 128'(go_ok), 128'(1));
        wk_done = 1'b1; step(); wk_done = 1'b0;
        chk("edge ack", 128'(req_ack), 128'(4'b0010));
        chk("edge err", 128'(req_err), 128'(0));
        req = '0; step(); step();

        // Reset in the middle of a job.
        req = 4'b0100; step();
        chk("mid go", 128'(wk_go), 128'(1));
        step(); step();
        rst = 1'b1; req = '0; step();
        chk("mid rst go",    128'(wk_go),     128'(0));
        chk("mid rst ack",   128'(req_ack),   128'(0));
        chk("mid rst err",   128'(req_err),   128'(0));
        chk("mid rst busy",  128'(busy),      128'(0));
        chk("mid rst gid",   128'(grant_id),  128'(0));
        chk("mid rst addr",  128'(wk_addr),   128'(0));
        chk("mid rst wdata", wk_wdata,        128'(0));
        chk("mid rst write", 128'(wk_write),  128'(0));
        chk("mid rst rdata", req_rdata,       128'(0));
        rst = 1'b0; step();
        chk("mid no ack", 128'(req_ack), 128'(0));
        req = 4'b1000; step();
        chk("post rst go",  128'(wk_go),    128'(1));
        chk("post rst gid", 128'(grant_id), 128'(3));
        wk_done = 1'b1; step(); wk_done = 1'b0;
        chk("post rst ack", 128'(req_ack), 128'(4'b1000));
        req = '0; step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
